song_beat_sequencer: RTL

- Generates the `beats` index that drives the harmony and melody note-lookup players.
- Steps through the song at a selectable tempo, with play, pause, stop and loop controls.
- Drives a per-beat articulation mute so that repeated identical notes are heard as separate notes.
- Sits between the board push-buttons/switches and the note-lookup players; its outputs also gate the audio output stage.

---
 rtl/song_pkg.sv | 16 +
 rtl/beat_prescaler.sv | 24 ++
 rtl/song_beat_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/song_pkg.sv
// Shared song sequencing types and constants, also used by the note-lookup players.
package song_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

  // tempo_sel encoding: the beat period is 2*BEAT_CYCLES shifted right by this value.
  localparam logic [1:0] TEMPO_HALF = 2'd0;
  localparam logic [1:0] TEMPO_NOM  = 2'd1;
  localparam logic [1:0] TEMPO_2X   = 2'd2;
  localparam logic [1:0] TEMPO_4X   = 2'd3;

  // Song length and the index that the lookup players treat as silence.
  localparam int SONG_LEN_DEF = 168;
  localparam int END_BEAT_DEF = 168;

endpackage

// File: rtl/beat_prescaler.sv
// Beat prescaler: counts clock cycles within a beat and flags the last cycle.
module beat_prescaler #(
  parameter int CNT_W = 24
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  // tick marks the final cycle of the beat; it only fires while counting.
  assign tick = en && (count == period - CNT_W'(1));

  // Cycle counter: clear wins, otherwise advance and wrap on the final cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)     count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= tick ? '0 : count + CNT_W'(1);
  end

endmodule

// File: rtl/song_beat_sequencer.sv
// Song beat sequencer: steps the beat index at a selectable tempo with
// play/pause/stop/loop controls and an end-of-beat articulation mute.
module song_beat_sequencer
  import song_pkg::*;
#(
  parameter int BEAT_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 500000,
  parameter int SONG_LEN    = SONG_LEN_DEF,
  parameter int END_BEAT    = END_BEAT_DEF,
  parameter int CNT_W       = 24
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       play,
  input  logic       pause,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [1:0] tempo_sel,
  output logic [7:0] beats,
  output logic       note_mute,
  output logic       beat_tick,
  output logic       playing,
  output logic       done
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(2 * BEAT_CYCLES);
  localparam logic [CNT_W:0]   GAP  = (CNT_W+1)'(GAP_CYCLES);
  localparam logic [7:0]       LAST = 8'(SONG_LEN - 1);
  localparam logic [7:0]       ENDB = 8'(END_BEAT);

  state_t           state_q, state_n;
  logic [7:0]       beats_n;
  logic [CNT_W-1:0] period_q, period_n, sel_period;
  logic [CNT_W-1:0] count, cnt_n;
  logic             tick_w, tick_n, run, clr, mute_n;

  // Beat period requested by the tempo switches.
  always_comb begin
    sel_period = BASE >> 1;
    case (tempo_sel)
      TEMPO_HALF: sel_period = BASE;
      TEMPO_NOM:  sel_period = BASE >> 1;
      TEMPO_2X:   sel_period = BASE >> 2;
      TEMPO_4X:   sel_period = BASE >> 3;
      default:    sel_period = BASE >> 1;
    endcase
  end

  // Prescaler advances only in PLAY with no competing command this cycle,
  // so a pause/stop landing on the final cycle suppresses the tick.
  assign run = (state_q == PLAY) && !stop && !pause;
  assign clr = ((state_q == IDLE || state_q == DONE) && play) ||
               ((state_q == PLAY || state_q == PAUSE) && stop);

  beat_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .en       (run),
    .clr      (clr),
    .period   (period_q),
    .count    (count),
    .tick     (tick_w)
  );

  // Next-state, beat index, latched period and tick; stop > pause > play.
  always_comb begin
    state_n  = state_q;
    beats_n  = beats;
    period_n = period_q;
    tick_n   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (play) begin
          state_n  = PLAY;
          beats_n  = 8'd0;
          period_n = sel_period;
        end
      end
      PLAY: begin
        if (stop) begin
          state_n = IDLE;
          beats_n = ENDB;
        end else if (pause) begin
          state_n = PAUSE;
        end else if (tick_w) begin
          tick_n   = 1'b1;
          period_n = sel_period;
          if (beats == LAST) begin
            if (loop_en) begin
              beats_n = 8'd0;
            end else begin
              state_n = DONE;
              beats_n = ENDB;
            end
          end else begin
            beats_n = beats + 8'd1;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_n = IDLE;
          beats_n = ENDB;
        end else if (!pause && play) begin
          state_n = PLAY;
        end
      end
      default: begin
        state_n = IDLE;
        beats_n = ENDB;
      end
    endcase
  end

  // Mirror the prescaler's next value so the mute register lines up with it.
  // The sum form avoids underflow when the period is no longer than the gap.
  always_comb begin
    cnt_n = count;
    if (clr)      cnt_n = '0;
    else if (run) cnt_n = tick_w ? '0 : count + CNT_W'(1);
    mute_n = (state_n != PLAY) || (({1'b0, cnt_n} + GAP) >= {1'b0, period_n});
  end

  // Output and control registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      beats     <= ENDB;
      period_q  <= BASE >> 1;
      note_mute <= 1'b1;
      beat_tick <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      beats     <= beats_n;
      period_q  <= period_n;
      note_mute <= mute_n;
      beat_tick <= tick_n;
      playing   <= (state_n == PLAY);
      done      <= (state_n == DONE);
    end
  end

endmodule
